qspi_phase_sequencer: RTL and testbench
=======================================

// Module: qspi_phase_sequencer
// PURPOSE
// Sequences one QSPI transfer through the CMD, ADDR, MODE, DUMMY and DATA phases.
// Drives the shared beat counter (start_count/target_count/xip_field_in -> count_done) once per phase.
// Owns chip-select timing, the IO output-enable and the transfer-complete/abort status toward the AHB-side FSM.
// In XIP mode the CMD phase is skipped.
// PARAMETERS
// CS_IDLE_CYC  2  min cycles cs_n stays high after a transfer before next start is accepted (>=1)
// PORTS
// clk          in   1  system clock
// rst_n        in   1  asynchronous active-low reset
// start        in   1  request new transfer; accepted only in IDLE with idle timer expired
// xip_mode     in   1  1 = execute-in-place: skip CMD phase
// rd_nwr       in   1  1 = read (DATA phase is input), 0 = write
// cmd_beats    in   4  CMD phase beat count; 0 = phase skipped
// addr_beats   in   4  ADDR phase beat count; 0 = skipped
// mode_beats   in   4  MODE phase beat count; 0 = skipped
// dummy_beats  in   4  DUMMY phase beat count; 0 = skipped
// data_beats   in   4  DATA phase beat count; 0 = skipped
// abort        in   1  terminate current transfer
// count_done   in   1  beat counter: current phase complete (1-cycle pulse)
// start_count  out  1  beat counter enable for current phase
// target_count out  4  beat count of current phase
// xip_field_in out  1  latched xip_mode forwarded to counter
// phase        out  3  0 IDLE,1 CMD,2 ADDR,3 MODE,4 DUMMY,5 DATA,6 DONE
// cs_n         out  1  flash chip select, active low
// io_oe        out  1  1 = controller drives IO lines
// busy         out  1  1 whenever phase != IDLE or idle timer running
// xfer_done    out  1  1-cycle pulse: transfer completed normally
// aborted      out  1  1-cycle pulse: transfer terminated by abort
// BEHAVIOUR
// - Reset: phase=IDLE, cs_n=1, start_count=0, target_count=0, xip_field_in=0, io_oe=0, busy=0, xfer_done=0, aborted=0, idle timer=0.
// - Accept: start=1 in IDLE with idle timer 0 latches all config inputs. Config changes afterward are ignored.
// - Start while busy is ignored. No queuing.
// - Cycle after accept: phase = first phase with nonzero beats in order CMD,ADDR,MODE,DUMMY,DATA.
//   CMD is always treated as zero when xip latched. cs_n goes low that same cycle.
// - All counts zero: phase goes to DONE the cycle after accept. cs_n never falls.
// - In an active phase:
//   - start_count=1; target_count = latched beats of that phase.
//   - Hold both until count_done is sampled 1.
// - On count_done=1: next cycle phase = next nonzero phase (or DONE).
//   - start_count=0 for exactly that one gap cycle (lets the counter clear), then reasserts.
//   - target_count updates in the gap cycle.
// - count_done outside an active phase, or during the gap cycle, is ignored.
// - DONE: lasts 1 cycle with cs_n=1, start_count=0, xfer_done=1. Next cycle IDLE.
//   - Idle timer loads CS_IDLE_CYC-1 and counts to 0. busy=1 until it reaches 0.
// - io_oe=1 in CMD, ADDR, MODE. io_oe=!rd_nwr(latched) in DATA. io_oe=0 in DUMMY/IDLE/DONE.
// - abort=1 in any active phase or the gap cycle:
//   - Next cycle IDLE, cs_n=1, start_count=0, aborted=1 for 1 cycle, xfer_done=0.
//   - Idle timer loads as after DONE.
// - abort in IDLE/DONE: no effect. abort and count_done in the same cycle: abort wins.
// - Async reset mid-transfer: immediate return to reset values. cs_n rises asynchronously.
// TESTING
// - cmd=1,addr=3,mode=0,dummy=4,data=7, xip=0, rd=1:
//   - phases 1,2,4,5 each hold target 1,3,4,7; gap of 1 cycle between them.
//   - io_oe 1,1,0,0; xfer_done pulses once.
// - Same config with xip=1: CMD skipped, first phase=ADDR, xip_field_in=1 throughout.
// - All beats 0: DONE the cycle after start, cs_n stays 1, xfer_done=1, no start_count.
// - abort in DUMMY coincident with count_done: next cycle IDLE, aborted=1, xfer_done=0, cs_n=1.
// - start held high across DONE with CS_IDLE_CYC=2: new accept no earlier than 2 cycles after cs_n rises.
// - rst_n low during DATA: all outputs at reset values immediately; following start runs a clean transfer.

Source files
------------

// File: rtl/qspi_phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : qspi_phase_sequencer
//  Description : Steps one QSPI transfer through CMD/ADDR/MODE/DUMMY/DATA,
//                drives the shared beat counter once per phase, and owns
//                chip-select timing, IO output-enable and completion status.
//  Revision    : 1.0  initial release
// ============================================================================
module qspi_phase_sequencer #(
   parameter int CS_IDLE_CYC = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       xip_mode,
   input  logic       rd_nwr,
   input  logic [3:0] cmd_beats,
   input  logic [3:0] addr_beats,
   input  logic [3:0] mode_beats,
   input  logic [3:0] dummy_beats,
   input  logic [3:0] data_beats,
   input  logic       abort,
   input  logic       count_done,
   output logic       start_count,
   output logic [3:0] target_count,
   output logic       xip_field_in,
   output logic [2:0] phase,
   output logic       cs_n,
   output logic       io_oe,
   output logic       busy,
   output logic       xfer_done,
   output logic       aborted
);

   localparam logic [2:0] PH_IDLE  = 3'd0;
   localparam logic [2:0] PH_CMD   = 3'd1;
   localparam logic [2:0] PH_ADDR  = 3'd2;
   localparam logic [2:0] PH_MODE  = 3'd3;
   localparam logic [2:0] PH_DUMMY = 3'd4;
   localparam logic [2:0] PH_DATA  = 3'd5;
   localparam logic [2:0] PH_DONE  = 3'd6;

   localparam int               TMR_W    = (CS_IDLE_CYC > 1) ? $clog2(CS_IDLE_CYC) : 1;
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(CS_IDLE_CYC - 1);

   logic [2:0]       r_phase;
   logic             r_gap;
   logic [3:0]       r_cmd_beats;
   logic [3:0]       r_addr_beats;
   logic [3:0]       r_mode_beats;
   logic [3:0]       r_dummy_beats;
   logic [3:0]       r_data_beats;
   logic             r_xip;
   logic             r_rd;
   logic [TMR_W-1:0] r_timer;
   logic             r_aborted;

   logic [2:0]       w_next_phase;
   logic             w_next_gap;
   logic             w_accept;
   logic             w_active;
   logic [5:1]       w_nz_in;
   logic [5:1]       w_nz_lat;

   // Lowest-numbered phase after 'cur' whose beat count is nonzero, else DONE.
   function automatic logic [2:0] next_nonzero(input logic [2:0] cur, input logic [5:1] nz);
      logic [2:0] res;
      res = PH_DONE;
      for (int i = 5; i >= 1; i--) begin
         if ((i > int'(cur)) && nz[i]) begin
            res = 3'(i);
         end
      end
      return res;
   endfunction

   // XIP forces the CMD phase to count as empty.
   assign w_nz_in  = {data_beats != 4'd0, dummy_beats != 4'd0, mode_beats != 4'd0,
                      addr_beats != 4'd0, (cmd_beats != 4'd0) && !xip_mode};
   assign w_nz_lat = {r_data_beats != 4'd0, r_dummy_beats != 4'd0, r_mode_beats != 4'd0,
                      r_addr_beats != 4'd0, (r_cmd_beats != 4'd0) && !r_xip};

   assign w_accept = (r_phase == PH_IDLE) && (r_timer == '0) && start;
   assign w_active = (r_phase >= PH_CMD) && (r_phase <= PH_DATA);

   // State register: current phase and the one-cycle counter-clear gap flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase <= PH_IDLE;
         r_gap   <= 1'b0;
      end else begin
         r_phase <= w_next_phase;
         r_gap   <= w_next_gap;
      end
   end

   // Next-state logic: accept, phase advance on count_done, abort, DONE exit.
   always_comb begin
      w_next_phase = r_phase;
      w_next_gap   = 1'b0;
      case (r_phase)
         PH_IDLE: begin
            if (w_accept) begin
               w_next_phase = next_nonzero(PH_IDLE, w_nz_in);
            end
         end
         PH_CMD, PH_ADDR, PH_MODE, PH_DUMMY, PH_DATA: begin
            if (abort) begin
               w_next_phase = PH_IDLE;
            end else if (!r_gap && count_done) begin
               w_next_phase = next_nonzero(r_phase, w_nz_lat);
               w_next_gap   = (w_next_phase != PH_DONE);
            end
         end
         default: begin
            w_next_phase = PH_IDLE;
         end
      endcase
   end

   // Output logic: all phase-derived outputs decode directly from state.
   always_comb begin
      start_count  = w_active && !r_gap;
      cs_n         = !w_active;
      xfer_done    = (r_phase == PH_DONE);
      busy         = (r_phase != PH_IDLE) || (r_timer != '0);
      target_count = 4'd0;
      io_oe        = 1'b0;
      case (r_phase)
         PH_CMD:   begin target_count = r_cmd_beats;   io_oe = 1'b1;  end
         PH_ADDR:  begin target_count = r_addr_beats;  io_oe = 1'b1;  end
         PH_MODE:  begin target_count = r_mode_beats;  io_oe = 1'b1;  end
         PH_DUMMY: begin target_count = r_dummy_beats; io_oe = 1'b0;  end
         PH_DATA:  begin target_count = r_data_beats;  io_oe = !r_rd; end
         default:  begin target_count = 4'd0;          io_oe = 1'b0;  end
      endcase
   end

   assign phase        = r_phase;
   assign xip_field_in = r_xip;
   assign aborted      = r_aborted;

   // Transfer configuration is captured only at accept and held until the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmd_beats   <= 4'd0;
         r_addr_beats  <= 4'd0;
         r_mode_beats  <= 4'd0;
         r_dummy_beats <= 4'd0;
         r_data_beats  <= 4'd0;
         r_xip         <= 1'b0;
         r_rd          <= 1'b0;
      end else if (w_accept) begin
         r_cmd_beats   <= cmd_beats;
         r_addr_beats  <= addr_beats;
         r_mode_beats  <= mode_beats;
         r_dummy_beats <= dummy_beats;
         r_data_beats  <= data_beats;
         r_xip         <= xip_mode;
         r_rd          <= rd_nwr;
      end
   end

   // Idle timer keeps cs_n high long enough after DONE or abort; abort status pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_timer   <= '0;
         r_aborted <= 1'b0;
      end else begin
         r_aborted <= w_active && abort;
         if ((r_phase == PH_DONE) || (w_active && abort)) begin
            r_timer <= TMR_LOAD;
         end else if (r_timer != '0) begin
            r_timer <= r_timer - 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_qspi_phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qspi_phase_sequencer
//  Description : Directed self-checking bench for qspi_phase_sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_qspi_phase_sequencer;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       xip_mode;
   logic       rd_nwr;
   logic [3:0] cmd_beats;
   logic [3:0] addr_beats;
   logic [3:0] mode_beats;
   logic [3:0] dummy_beats;
   logic [3:0] data_beats;
   logic       abort;
   logic       count_done;
   logic       start_count;
   logic [3:0] target_count;
   logic       xip_field_in;
   logic [2:0] phase;
   logic       cs_n;
   logic       io_oe;
   logic       busy;
   logic       xfer_done;
   logic       aborted;

   int n_vec = 0;
   int n_err = 0;

   qspi_phase_sequencer #(.CS_IDLE_CYC(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .xip_mode     (xip_mode),
      .rd_nwr       (rd_nwr),
      .cmd_beats    (cmd_beats),
      .addr_beats   (addr_beats),
      .mode_beats   (mode_beats),
      .dummy_beats  (dummy_beats),
      .data_beats   (data_beats),
      .abort        (abort),
      .count_done   (count_done),
      .start_count  (start_count),
      .target_count (target_count),
      .xip_field_in (xip_field_in),
      .phase        (phase),
      .cs_n         (cs_n),
      .io_oe        (io_oe),
      .busy         (busy),
      .xfer_done    (xfer_done),
      .aborted      (aborted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compare the full output set against hand-computed values.
   task automatic expect_out(input string tag, input logic [2:0] ph, input logic cs,
                             input logic sc, input logic [3:0] tc, input logic oe,
                             input logic bsy, input logic xd, input logic ab);
      chk({tag, ".phase"},  8'(phase),        8'(ph));
      chk({tag, ".cs_n"},   8'(cs_n),         8'(cs));
      chk({tag, ".sc"},     8'(start_count),  8'(sc));
      chk({tag, ".tc"},     8'(target_count), 8'(tc));
      chk({tag, ".io_oe"},  8'(io_oe),        8'(oe));
      chk({tag, ".busy"},   8'(busy),         8'(bsy));
      chk({tag, ".xdone"},  8'(xfer_done),    8'(xd));
      chk({tag, ".abrt"},   8'(aborted),      8'(ab));
   endtask

   // One clock with count_done driven for that cycle; outputs settle 1ns after the edge.
   task automatic cyc(input logic cd);
      count_done = cd;
      @(posedge clk);
      #1;
      count_done = 1'b0;
   endtask

   task automatic set_cfg(input logic x, input logic rd, input logic [3:0] c, input logic [3:0] a,
                          input logic [3:0] m, input logic [3:0] d, input logic [3:0] dt);
      xip_mode = x; rd_nwr = rd; cmd_beats = c; addr_beats = a;
      mode_beats = m; dummy_beats = d; data_beats = dt;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; count_done = 1'b0;
      set_cfg(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
      #12;
      expect_out("rst", 3'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst.xip", 8'(xip_field_in), 8'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      cyc(1'b0);

      // Transfer 1: cmd=1 addr=3 mode=0 dummy=4 data=7, read, no XIP.
      set_cfg(1'b0, 1'b1, 4'd1, 4'd3, 4'd0, 4'd4, 4'd7);
      start = 1'b1;
      cyc(1'b0);
      start = 1'b0;
      set_cfg(1'b1, 1'b0, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15);   // must be ignored
      expect_out("t1.cmd", 3'd1, 1'b0, 1'b1, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("t1.xip", 8'(xip_field_in), 8'd0);
      cyc(1'b0);
      expect_out("t1.cmd_hold", 3'd1, 1'b0, 1'b1, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1);
      expect_out("t1.addr_gap", 3'd2, 1'b0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1);                                                  // ignored in gap
      expect_out("t1.addr", 3'd2, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1);
      expect_out("t1.dummy_gap", 3'd4, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0);
      expect_out("t1.dummy", 3'd4, 1'b0, 1'b1, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1);
      expect_out("t1.data_gap", 3'd5, 1'b0, 1'b0, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0);
      expect_out("t1.data", 3'd5, 1'b0, 1'b1, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1);
      expect_out("t1.done", 3'd6, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      cyc(1'b0);
      expect_out("t1.idle_t", 3'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0);
      expect_out("t1.idle", 3'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Transfer 2: XIP skips CMD; start held high the whole way through DONE.
      set_cfg(1'b1, 1'b1, 4'd1, 4'd3, 4'd0, 4'd4, 4'd7);
      start = 1'b1;
      cyc(1'b0);
      expect_out("t2.addr", 3'd2, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("t2.xip_a", 8'(xip_field_in), 8'd1);
      cyc(1'b1);
      cyc(1'b0);
      expect_out("t2.dummy", 3'd4, 1'b0, 1'b1, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1);
      cyc(1'b0);
      expect_out("t2.data", 3'd5, 1'b0, 1'b1, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("t2.xip_d", 8'(xip_field_in), 8'd1);
      cyc(1'b1);
      expect_out("t2.done", 3'd6, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      cyc(1'b0);
      expect_out("t2.hold1", 3'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0);
      expect_out("t2.hold2", 3'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0);
      expect_out("t2.reacc", 3'd2, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      start = 1'b0;

      // Abort in DUMMY coincident with count_done.
      cyc(1'b1);
      cyc(1'b0);
      expect_out("t4.dummy", 3'd4, 1'b0, 1'b1, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0);
      abort = 1'b1;
      cyc(1'b1);
      abort = 1'b0;
      expect_out("t4.abort", 3'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      cyc(1'b0);
      expect_out("t4.post", 3'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Abort in IDLE has no effect.
      abort = 1'b1;
      cyc(1'b0);
      abort = 1'b0;
      expect_out("t4.idle_ab", 3'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Transfer 3: all beats zero goes straight to DONE, cs_n never falls.
      set_cfg(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
      start = 1'b1;
      cyc(1'b0);
      start = 1'b0;
      expect_out("t3.done", 3'd6, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("t3.xip", 8'(xip_field_in), 8'd0);
      cyc(1'b0);
      expect_out("t3.idle_t", 3'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0);

      // Transfer 4: write, reset asserted during DATA.
      set_cfg(1'b0, 1'b0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd2);
      start = 1'b1;
      cyc(1'b0);
      start = 1'b0;
      expect_out("t6.cmd", 3'd1, 1'b0, 1'b1, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1);
      expect_out("t6.data_gap", 3'd5, 1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b0);
      expect_out("t6.data_wr", 3'd5, 1'b0, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      expect_out("t6.async_rst", 3'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Clean read transfer after reset.
      set_cfg(1'b0, 1'b1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd2);
      start = 1'b1;
      cyc(1'b0);
      start = 1'b0;
      expect_out("t7.cmd", 3'd1, 1'b0, 1'b1, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1);
      cyc(1'b0);
      expect_out("t7.data_rd", 3'd5, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1);
      expect_out("t7.done", 3'd6, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      cyc(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
